mdio_master: RTL and testbench

Clause-22 MDIO management controller that replaces software bit-banging of the PHY MDC/MDIO pins. It is programmed over the OPB GPIO register path, generates MDC from OPB_CLK, serialises read and write management frames to the Ethernet PHY, and returns read data and status to the host. It sits between the OPB decode and the PHY_MDC/PHY_MDIO pads.

---
 rtl/mdio_master.sv | 176 +++++++++++++++++
 tb/tb_mdio_master.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master on the OPB GPIO register path.
// CMD (ADDR[2]=0, write) launches a read or write frame; STATUS (ADDR[2]=1,
// read) returns BUSY/DONE/ERR_BUSY/NOACK and the last read data.
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN (CMD.PS=1 skips preamble).
module mdio_master #(
  parameter int CLK_DIV       = 20,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [31:0] OPB_DI,
  input  logic [31:0] OPB_ADDR,
  input  logic        MDIO_RE,
  input  logic        MDIO_WE,
  output logic [31:0] OPB_DO,
  output logic        PHY_MDC,
  output logic        PHY_MDIO_O,
  output logic        PHY_MDIO_OE,
  input  logic        PHY_MDIO_I,
  output logic        MDIO_IRQ
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_FIN} state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_M1 = 6'(PREAMBLE_BITS - 1);

  state_t      r_state;
  logic [7:0]  r_div;
  logic [5:0]  r_cnt;
  logic [13:0] r_hdr;
  logic [15:0] r_wdata, r_shift, r_rdata;
  logic        r_op;
  logic        r_mdc, r_o, r_oe;
  logic        r_done, r_err, r_noack;
  logic [31:0] r_do;

  logic        w_busy, w_tick, w_rise, w_fall;
  logic        w_cmd_we, w_sts_re, w_ps;
  logic        w_done_set, w_err_set, w_noack_set;
  logic [5:0]  w_cnt_m1;
  logic [13:0] w_hdr_new;
  logic        w_unused;

  assign w_busy     = (r_state != S_IDLE);
  assign w_tick     = w_busy && (r_div == DIV_M1);
  assign w_rise     = w_tick && !r_mdc;
  assign w_fall     = w_tick && r_mdc;
  assign w_cmd_we   = MDIO_WE && !OPB_ADDR[2];
  assign w_sts_re   = MDIO_RE && OPB_ADDR[2];
  assign w_cnt_m1   = r_cnt - 6'd1;
  // ST=01, OP (10 read / 01 write), PHYAD, REGAD -- sent from bit 13 down
  assign w_hdr_new  = {2'b01, (OPB_DI[10] ? 2'b10 : 2'b01), OPB_DI[9:5], OPB_DI[4:0]};
  assign w_done_set = w_fall && (r_state == S_FIN);
  assign w_err_set  = w_cmd_we && w_busy;
  // second turnaround bit must be pulled low by the PHY on a read
  assign w_noack_set = w_rise && (r_state == S_TA) && (r_cnt == 6'd0) && r_op && PHY_MDIO_I;
  assign w_unused   = ^{OPB_ADDR[31:3], OPB_ADDR[1:0], OPB_DI[15:11]};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign w_ps = OPB_DI[11];
`else
  assign w_ps = 1'b0;
`endif

  // Frame sequencer: MDC divider, bit counter, pin drive and read-data capture
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_wdata <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_op    <= 1'b0;
      r_mdc   <= 1'b0;
      r_o     <= 1'b1;
      r_oe    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_div <= '0;
      r_mdc <= 1'b0;
      if (w_cmd_we) begin
        r_hdr   <= w_hdr_new;
        r_wdata <= OPB_DI[31:16];
        r_op    <= OPB_DI[10];
        r_oe    <= 1'b1;
        if (w_ps) begin
          r_state <= S_HDR;
          r_cnt   <= 6'd13;
          r_o     <= w_hdr_new[13];
        end else begin
          r_state <= S_PRE;
          r_cnt   <= PRE_M1;
          r_o     <= 1'b1;
        end
      end
    end else begin
      r_div <= w_tick ? 8'd0 : r_div + 8'd1;
      if (w_tick) r_mdc <= ~r_mdc;
      // PHY data is taken on MDC rising edges during DATA
      if (w_rise && r_state == S_DATA) r_shift <= {r_shift[14:0], PHY_MDIO_I};
      // all pin changes and bit advances happen on MDC falling edges
      if (w_fall) begin
        if (r_cnt != 6'd0) r_cnt <= w_cnt_m1;
        case (r_state)
          S_PRE: begin
            if (r_cnt == 6'd0) begin
              r_state <= S_HDR;
              r_cnt   <= 6'd13;
              r_o     <= r_hdr[13];
            end
          end
          S_HDR: begin
            if (r_cnt == 6'd0) begin
              r_state <= S_TA;
              r_cnt   <= 6'd1;
              r_o     <= 1'b1;
              r_oe    <= !r_op;
            end else begin
              r_o <= r_hdr[w_cnt_m1[3:0]];
            end
          end
          S_TA: begin
            if (r_cnt == 6'd0) begin
              r_state <= S_DATA;
              r_cnt   <= 6'd15;
              r_o     <= r_wdata[15];
            end else begin
              r_o <= 1'b0;
            end
          end
          S_DATA: begin
            if (r_cnt == 6'd0) begin
              r_state <= S_FIN;
              r_o     <= 1'b1;
              r_oe    <= 1'b0;
            end else begin
              r_o <= r_wdata[w_cnt_m1[3:0]];
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            r_o     <= 1'b1;
            r_oe    <= 1'b0;
            if (r_op) r_rdata <= r_shift;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Sticky status bits (a set in the same cycle beats the clear-on-read) and read port
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_noack <= 1'b0;
      r_do    <= '0;
    end else begin
      r_done  <= w_done_set  || (r_done  && !w_sts_re);
      r_err   <= w_err_set   || (r_err   && !w_sts_re);
      r_noack <= w_noack_set || (r_noack && !w_sts_re);
      if (MDIO_RE)
        r_do <= OPB_ADDR[2] ? {r_rdata, 12'd0, r_noack, r_err, r_done, w_busy} : 32'd0;
    end
  end

  assign OPB_DO      = r_do;
  assign PHY_MDC     = r_mdc;
  assign PHY_MDIO_O  = r_o;
  assign PHY_MDIO_OE = r_oe;
  assign MDIO_IRQ    = r_done;

endmodule

// File: tb/tb_mdio_master.sv
`define CHK(tag, o, e) begin \
  n_assert++; \
  assert (80'(o) === 80'(e)) else begin \
    n_fail++; \
    $error("FAIL %s: observed %0h expected %0h", tag, 80'(o), 80'(e)); \
  end \
end

module tb_mdio_master;
  logic        OPB_CLK = 1'b0;
  logic        OPB_RST;
  logic [31:0] OPB_DI, OPB_ADDR;
  logic        MDIO_RE, MDIO_WE;
  logic [31:0] OPB_DO;
  logic        PHY_MDC, PHY_MDIO_O, PHY_MDIO_OE, PHY_MDIO_I, MDIO_IRQ;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int PS_CYC = 132;
  localparam int PS_PER = 33;
  localparam logic PS_FIRST = 1'b0;
`else
  localparam int PS_CYC = 260;
  localparam int PS_PER = 65;
  localparam logic PS_FIRST = 1'b1;
`endif

  mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .OPB_DI(OPB_DI), .OPB_ADDR(OPB_ADDR),
    .MDIO_RE(MDIO_RE), .MDIO_WE(MDIO_WE), .OPB_DO(OPB_DO), .PHY_MDC(PHY_MDC),
    .PHY_MDIO_O(PHY_MDIO_O), .PHY_MDIO_OE(PHY_MDIO_OE), .PHY_MDIO_I(PHY_MDIO_I),
    .MDIO_IRQ(MDIO_IRQ)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  logic [127:0] mon_o = '0, mon_oe = '0;
  int mon_n = 0;
  always @(posedge PHY_MDC) begin
    mon_o  <= {mon_o[126:0], PHY_MDIO_O};
    mon_oe <= {mon_oe[126:0], PHY_MDIO_OE};
    mon_n  <= mon_n + 1;
  end

  int falls = 0;
  int phy_base = 0;
  int phy_idx;
  logic phy_on;
  logic [15:0] phy_data;
  always @(negedge PHY_MDC) falls <= falls + 1;
  assign phy_idx = falls - phy_base;
  assign PHY_MDIO_I = (phy_on && phy_idx == 47) ? 1'b0 :
                      (phy_on && phy_idx >= 48 && phy_idx <= 63) ? phy_data[63 - phy_idx] : 1'b1;

  function automatic logic [63:0] exp_wr(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    return {32'hFFFF_FFFF, 2'b01, 2'b01, phy, ra, 2'b10, d};
  endfunction

  function automatic logic [45:0] exp_rd_hdr(input logic [4:0] phy, input logic [4:0] ra);
    return {32'hFFFF_FFFF, 2'b01, 2'b10, phy, ra};
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge OPB_CLK);
    MDIO_WE = 1'b1; OPB_ADDR = a; OPB_DI = d;
    @(negedge OPB_CLK);
    MDIO_WE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge OPB_CLK);
    MDIO_RE = 1'b1; OPB_ADDR = a;
    @(negedge OPB_CLK);
    MDIO_RE = 1'b0;
    d = OPB_DO;
  endtask

  task automatic wait_irq(output int cyc);
    cyc = 0;
    while (MDIO_IRQ !== 1'b1 && cyc < 2000) begin
      @(negedge OPB_CLK);
      cyc++;
    end
    n_assert++;
    if (MDIO_IRQ !== 1'b1) begin
      n_fail++;
      $error("FAIL wait_irq: IRQ not seen within %0d cycles", cyc);
    end
  endtask

  initial begin
    logic [31:0] d;
    int cyc, n0;
    OPB_RST = 1'b1; OPB_DI = '0; OPB_ADDR = '0; MDIO_RE = 1'b0; MDIO_WE = 1'b0;
    phy_on = 1'b0; phy_data = '0;
    repeat (3) @(negedge OPB_CLK);
    `CHK("rst mdc", PHY_MDC, 1'b0)
    `CHK("rst o", PHY_MDIO_O, 1'b1)
    `CHK("rst oe", PHY_MDIO_OE, 1'b0)
    `CHK("rst do", OPB_DO, 32'h0)
    `CHK("rst irq", MDIO_IRQ, 1'b0)
    OPB_RST = 1'b0;
    @(negedge OPB_CLK);
    rd(32'h4, d);
    n_assert++;
    if (d !== 32'h0) begin
      n_fail++;
      $error("FAIL rst status: observed %0h expected 0", d);
    end

    n0 = mon_n;
    wr(32'h0, 32'hBEEF_0024);
    `CHK("wr first mdc", PHY_MDC, 1'b0)
    `CHK("wr first oe", PHY_MDIO_OE, 1'b1)
    `CHK("wr first o", PHY_MDIO_O, 1'b1)
    wait_irq(cyc);
    `CHK("wr busy cycles", cyc, 260)
    `CHK("wr periods", mon_n - n0, 65)
    `CHK("wr trace o", mon_o[64:1], 64'hFFFF_FFFF_5092_BEEF)
    `CHK("wr trace oe", mon_oe[64:0], {{64{1'b1}}, 1'b0})
    rd(32'h4, d);
    `CHK("wr status", d, 32'h0000_0002)
    `CHK("irq cleared", MDIO_IRQ, 1'b0)
    repeat (3) @(negedge OPB_CLK);
    `CHK("do holds", OPB_DO, 32'h0000_0002)
    rd(32'h0, d);
    `CHK("cmd read", d, 32'h0)
    rd(32'h4, d);
    `CHK("done cleared", d, 32'h0)

    phy_data = 16'h1234; phy_on = 1'b1; phy_base = falls;
    n0 = mon_n;
    wr(32'h0, 32'h0000_0462);
    wait_irq(cyc);
    `CHK("rd cycles", cyc, 260)
    `CHK("rd trace hdr", mon_o[64:19], exp_rd_hdr(5'd3, 5'd2))
    `CHK("rd trace oe", mon_oe[64:0], {{46{1'b1}}, 19'd0})
    rd(32'h4, d);
    `CHK("rd status", d, 32'h1234_0002)
    rd(32'h4, d);
    `CHK("rd status 2", d, 32'h1234_0000)

    phy_on = 1'b0;
    wr(32'h0, 32'h0000_0462);
    wait_irq(cyc);
    rd(32'h4, d);
    `CHK("noack status", d, 32'hFFFF_000A)
    rd(32'h4, d);
    `CHK("noack cleared", d, 32'hFFFF_0000)

    n0 = mon_n;
    wr(32'h0, 32'hA5A5_0047);
    repeat (100) @(negedge OPB_CLK);
    wr(32'h0, 32'h1111_0000);
    rd(32'h4, d);
    `CHK("busy err status", d, 32'hFFFF_0005)
    wr(32'h0, 32'h2222_0400);
    wait_irq(cyc);
    `CHK("busy done", MDIO_IRQ, 1'b1)
    `CHK("busy periods", mon_n - n0, 65)
    `CHK("busy trace o", mon_o[64:1], exp_wr(5'd2, 5'd7, 16'hA5A5))
    rd(32'h4, d);
    `CHK("busy final status", d, 32'hFFFF_0006)
    n0 = mon_n;
    wr(32'h0, 32'h0F0F_03FF);
    wait_irq(cyc);
    `CHK("restart cycles", cyc, 260)
    `CHK("restart trace o", mon_o[64:1], exp_wr(5'd31, 5'd31, 16'h0F0F))
    rd(32'h4, d);

    wr(32'h0, 32'h5A5A_0001);
    repeat (4 * 19 + 2) @(negedge OPB_CLK);
    `CHK("pre20 mdc", PHY_MDC, 1'b1)
    OPB_RST = 1'b1;
    #1;
    `CHK("arst mdc", PHY_MDC, 1'b0)
    `CHK("arst oe", PHY_MDIO_OE, 1'b0)
    `CHK("arst o", PHY_MDIO_O, 1'b1)
    `CHK("arst irq", MDIO_IRQ, 1'b0)
    @(negedge OPB_CLK);
    OPB_RST = 1'b0;
    @(negedge OPB_CLK);
    rd(32'h4, d);
    `CHK("arst status", d, 32'h0)
    n0 = mon_n;
    wr(32'h0, 32'h5A5A_0001);
    wait_irq(cyc);
    `CHK("arst new cycles", cyc, 260)
    `CHK("arst new periods", mon_n - n0, 65)
    `CHK("arst new trace", mon_o[64:1], exp_wr(5'd0, 5'd1, 16'h5A5A))
    rd(32'h4, d);

    n0 = mon_n;
    wr(32'h0, 32'h0000_0823);
    `CHK("ps first o", PHY_MDIO_O, PS_FIRST)
    repeat (PS_CYC - 1) @(negedge OPB_CLK);
    MDIO_RE = 1'b1; OPB_ADDR = 32'h4;
    @(negedge OPB_CLK);
    MDIO_RE = 1'b0;
    `CHK("ps collide do", OPB_DO, 32'h0000_0001)
    `CHK("ps collide irq", MDIO_IRQ, 1'b1)
    `CHK("ps periods", mon_n - n0, PS_PER)
    rd(32'h4, d);
    `CHK("ps status", d, 32'h0000_0002)

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
